// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory responder.
// Bus widths, ISR window base, FSM state encoding and the latched request record.
package mem_responder_pkg;

    parameter int MEMORY_ADDRESS_BITS = 16;
    parameter int MEMORY_DATA_BITS    = 8;
    parameter logic [MEMORY_ADDRESS_BITS-1:0] ISR_ADDRESS = 16'hff00;

    parameter int MEM_WAIT_BITS    = 4;
    parameter int ISR_WINDOW_BYTES = 256;

    typedef enum bit [1:0] {MR_IDLE, MR_WAIT, MR_ACK} MemRespState;

    typedef struct packed {
        logic                           we;
        logic [MEMORY_ADDRESS_BITS-1:0] addr;
        logic [MEMORY_DATA_BITS-1:0]    wdata;
    } mem_req_t;

endpackage

// File: rtl/sp_byte_ram.sv
// Single-port byte array: synchronous write, combinational read.
// Contents are deliberately not reset.
module sp_byte_ram
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [AW-1:0]               addr,
    input  logic [MEMORY_DATA_BITS-1:0] wdata,
    output logic [MEMORY_DATA_BITS-1:0] rdata
);

    logic [MEMORY_DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for core load/store/fetch: low RAM + ISR window, fixed wait states.
// Define MEM_RESPONDER_ISR_PROTECT_EN to make the ISR window read-only (stores ack with err).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ISR_DEPTH   = ISR_WINDOW_BYTES,
    parameter int WAIT_STATES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           we,
    input  logic [MEMORY_ADDRESS_BITS-1:0] addr,
    input  logic [MEMORY_DATA_BITS-1:0]    wdata,
    output logic                           ack,
    output logic                           err,
    output logic [MEMORY_DATA_BITS-1:0]    rdata
);

    localparam int LO_AW  = $clog2(DEPTH);
    localparam int ISR_AW = $clog2(ISR_DEPTH);
    localparam int AB1    = MEMORY_ADDRESS_BITS + 1;

    localparam logic [AB1-1:0] LO_END  = AB1'(DEPTH);
    localparam logic [AB1-1:0] ISR_BEG = {1'b0, ISR_ADDRESS};
    localparam logic [AB1-1:0] ISR_END = {1'b0, ISR_ADDRESS} + AB1'(ISR_DEPTH);

    localparam logic [MEM_WAIT_BITS-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? MEM_WAIT_BITS'(WAIT_STATES - 1) : '0;

`ifdef MEM_RESPONDER_ISR_PROTECT_EN
    localparam logic ISR_RO = 1'b1;
`else
    localparam logic ISR_RO = 1'b0;
`endif

    MemRespState              state;
    logic [MEM_WAIT_BITS-1:0] cnt;
    mem_req_t                 lat;
    mem_req_t                 cur;

    logic [AB1-1:0]              a_ext;
    logic                        lo_hit, isr_hit, bad;
    logic [LO_AW-1:0]            lo_idx;
    logic [ISR_AW-1:0]           isr_idx;
    logic [MEMORY_DATA_BITS-1:0] lo_rdata, isr_rdata, rd_byte, resp_rdata;
    logic                        commit, go_ack;

    // In IDLE the bus inputs are decoded directly so a zero-wait ack can
    // be prepared on the accepting edge; afterwards only latched values count.
    always_comb begin
        cur = lat;
        if (state == MR_IDLE) begin
            cur.we    = we;
            cur.addr  = addr;
            cur.wdata = wdata;
        end
    end

    assign a_ext   = {1'b0, cur.addr};
    assign lo_hit  = (a_ext < LO_END);
    assign isr_hit = (a_ext >= ISR_BEG) && (a_ext < ISR_END);
    assign lo_idx  = cur.addr[LO_AW-1:0];
    assign isr_idx = ISR_AW'(cur.addr - ISR_ADDRESS);

    assign bad = !(lo_hit || isr_hit) || (cur.we && isr_hit && ISR_RO);

    always_comb begin
        rd_byte = '0;
        if (lo_hit)       rd_byte = lo_rdata;
        else if (isr_hit) rd_byte = isr_rdata;
    end

    assign resp_rdata = (cur.we || bad) ? '0 : rd_byte;

    assign go_ack = (state == MR_IDLE && req && WAIT_STATES == 0) ||
                    (state == MR_WAIT && cnt == '0);

    // Writes land on the edge that ends the ack cycle; a reset on that edge kills them.
    assign commit = (state == MR_ACK) && !reset && lat.we && !bad;

    sp_byte_ram #(.DEPTH(DEPTH)) u_lo_ram (
        .clk   (clk),
        .we    (commit && lo_hit),
        .addr  (lo_idx),
        .wdata (lat.wdata),
        .rdata (lo_rdata)
    );

    sp_byte_ram #(.DEPTH(ISR_DEPTH)) u_isr_ram (
        .clk   (clk),
        .we    (commit && isr_hit),
        .addr  (isr_idx),
        .wdata (lat.wdata),
        .rdata (isr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MR_IDLE;
            cnt   <= '0;
            lat   <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            if (go_ack) begin
                ack   <= 1'b1;
                err   <= bad;
                rdata <= resp_rdata;
            end
            case (state)
                MR_IDLE: begin
                    if (req) begin
                        lat.we    <= we;
                        lat.addr  <= addr;
                        lat.wdata <= wdata;
                        cnt       <= WAIT_LOAD;
                        state     <= (WAIT_STATES > 0) ? MR_WAIT : MR_ACK;
                    end
                end
                MR_WAIT: begin
                    if (cnt == '0) state <= MR_ACK;
                    else           cnt   <= cnt - 1'b1;
                end
                MR_ACK:  state <= MR_IDLE;
                default: state <= MR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (WAIT_STATES 1, 0, 3) against a flat byte-array model.
// Honours MEM_RESPONDER_ISR_PROTECT_EN the same way the design does.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ISR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_v   [3];
    logic       req_v   [3];
    logic       we_v    [3];
    logic [15:0] addr_v [3];
    logic [7:0] wdata_v [3];
    logic       ack_v   [3];
    logic       err_v   [3];
    logic [7:0] rdata_v [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH       (1024),
            .ISR_DEPTH   (256),
            .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .req   (req_v[g]),
            .we    (we_v[g]),
            .addr  (addr_v[g]),
            .wdata (wdata_v[g]),
            .ack   (ack_v[g]),
            .err   (err_v[g]),
            .rdata (rdata_v[g])
        );
    end

    int errors = 0;
    int checks = 0;

    // Reference model: plain byte arrays plus a "value known" flag per byte.
    logic [7:0] mdl [3][65536];
    bit         kn  [3][65536];

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    function automatic bit mapped(input logic [15:0] a);
        return (a < 16'd1024) || (a >= 16'hff00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access; starts and ends at a negedge with the DUT idle.
    task automatic access(input int i, input bit w, input logic [15:0] a,
                          input logic [7:0] d, input bit chg, input logic [15:0] a2,
                          output logic [7:0] rd);
        int n;
        bit exp_err;
        logic [7:0] exp_rd;
        exp_err = !mapped(a) || (w && a >= 16'hff00 && PROT);
        exp_rd  = (w || exp_err) ? 8'h00 : mdl[i][a];
        we_v[i] = w; addr_v[i] = a; wdata_v[i] = d; req_v[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (chg) begin
            addr_v[i] = a2;
            req_v[i]  = 1'b0;
        end
        n = 0;
        while (ack_v[i] !== 1'b1 && n < 40) begin
            @(posedge clk); n++; @(negedge clk);
        end
        req_v[i] = 1'b0;
        rd = rdata_v[i];
        chk("latency", n, ws_of(i));
        chk("err", err_v[i], exp_err);
        if (!w && !exp_err && !kn[i][a]) begin
            mdl[i][a] = rdata_v[i];
            kn[i][a]  = 1'b1;
        end else begin
            chk("rdata", rdata_v[i], exp_rd);
        end
        if (w && !exp_err) begin
            mdl[i][a] = d;
            kn[i][a]  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("ack_pulse", ack_v[i], 1'b0);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [7:0]  old;
        logic [15:0] bnd [6];
        int          n;
        bnd = '{16'h0000, 16'h03ff, 16'h0400, 16'hfeff, 16'hff00, 16'hffff};

        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; req_v[i] = 1'b1; we_v[i] = 1'b0;
            addr_v[i] = 16'h0; wdata_v[i] = 8'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", ack_v[i], 1'b0);
            chk("rst_err", err_v[i], 1'b0);
            chk("rst_rdata", rdata_v[i], 8'h00);
            req_v[i] = 1'b0;
            rst_v[i] = 1'b0;
        end
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < 3; i++) chk("idle_ack", ack_v[i], 1'b0);
        end

        // Fill the whole low window of instance 0 so later aliasing shows up.
        for (int a = 0; a < 1024; a++)
            access(0, 1'b1, 16'(a), 8'($urandom), 1'b0, 16'h0, rd);
        access(0, 1'b1, 16'h0020, 8'h5a, 1'b0, 16'h0, rd);

        access(0, 1'b1, 16'h0010, 8'ha5, 1'b0, 16'h0, rd);
        access(0, 1'b0, 16'h0010, 8'h00, 1'b0, 16'h0, rd);
        chk("load_a5", rd, 8'ha5);

        access(0, 1'b1, 16'hff00, 8'h3c, 1'b0, 16'h0, rd);
        access(0, 1'b0, 16'hff00, 8'h00, 1'b0, 16'h0, rd);
        if (PROT) chk("isr_protected", (rd == 8'h3c), 1'b0);
        else      chk("isr_3c", rd, 8'h3c);
        access(0, 1'b0, 16'hffff, 8'h00, 1'b0, 16'h0, rd);
        access(0, 1'b0, 16'hffff, 8'h00, 1'b0, 16'h0, rd);

        access(0, 1'b0, 16'h0400, 8'h00, 1'b0, 16'h0, rd);
        chk("unmapped_rd", rd, 8'h00);
        access(0, 1'b1, 16'h8000, 8'h11, 1'b0, 16'h0, rd);
        access(0, 1'b1, 16'hfeff, 8'h22, 1'b0, 16'h0, rd);
        for (int a = 0; a < 1024; a++)
            access(0, 1'b0, 16'(a), 8'h00, 1'b0, 16'h0, rd);

        // Reset during MR_WAIT: store must vanish, no ack.
        we_v[0] = 1'b1; addr_v[0] = 16'h0020; wdata_v[0] = 8'h77; req_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0; rst_v[0] = 1'b1;
        chk("rst_wait_ack", ack_v[0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_v[0] = 1'b0;
        repeat (4) begin
            chk("rst_wait_noack", ack_v[0], 1'b0);
            @(posedge clk); @(negedge clk);
        end
        access(0, 1'b0, 16'h0020, 8'h00, 1'b0, 16'h0, rd);
        chk("rst_wait_old", rd, 8'h5a);

        // Zero wait states, req held high: ack on every second cycle.
        for (int a = 1; a <= 3; a++)
            access(1, 1'b1, 16'(a), 8'(8'h40 + a), 1'b0, 16'h0, rd);
        we_v[1] = 1'b0; addr_v[1] = 16'h0001; req_v[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_ack", ack_v[1], (c % 2 == 0));
            if (c % 2 == 0) begin
                chk("b2b_rdata", rdata_v[1], 8'h41 + 8'(c / 2));
                chk("b2b_err", err_v[1], 1'b0);
                addr_v[1] = 16'(2 + c / 2);
            end
            if (c == 4) req_v[1] = 1'b0;
        end

        // Three wait states: address moves and req drops after acceptance.
        access(2, 1'b1, 16'h0005, 8'hc5, 1'b0, 16'h0, rd);
        access(2, 1'b1, 16'h0006, 8'hc6, 1'b0, 16'h0, rd);
        access(2, 1'b0, 16'h0005, 8'h00, 1'b1, 16'h0006, rd);
        chk("latched_addr", rd, 8'hc5);

        // Reset coinciding with the ack cycle discards the store.
        old = mdl[2][5];
        we_v[2] = 1'b1; addr_v[2] = 16'h0005; wdata_v[2] = ~old; req_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v[2] = 1'b0;
        n = 0;
        while (ack_v[2] !== 1'b1 && n < 40) begin
            @(posedge clk); n++; @(negedge clk);
        end
        chk("rst_ack_lat", n, 3);
        rst_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_v[2] = 1'b0;
        chk("rst_ack_drop", ack_v[2], 1'b0);
        access(2, 1'b0, 16'h0005, 8'h00, 1'b0, 16'h0, rd);
        chk("rst_ack_old", rd, old);

        // Randomised traffic across all windows on every instance.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 80; k++) begin
                logic [15:0] a;
                case ($urandom_range(0, 3))
                    0:       a = 16'($urandom_range(0, 1023));
                    1:       a = 16'hff00 + 16'($urandom_range(0, 255));
                    2:       a = 16'($urandom_range(1024, 16'hfeff));
                    default: a = bnd[$urandom_range(0, 5)];
                endcase
                access(i, 1'($urandom), a, 8'($urandom), 1'b0, 16'h0, rd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the core's load/store/fetch bus: answers requests that the core issues during LOAD_STAGE, STORE_STAGE and fetch.
- Holds two byte arrays:
  - a low RAM window at 0x0000..DEPTH-1;
  - an ISR window at ISR_ADDRESS..ISR_ADDRESS+ISR_DEPTH-1 (0xff00..0xffff by default).
- Every request gets exactly one ack pulse after a programmable number of wait states, plus an error flag for unmapped addresses.

Parameters:
- DEPTH, 1024, bytes in the low RAM window. Must be ≤ ISR_ADDRESS and a power of two.
- ISR_DEPTH, 256, bytes in the ISR window starting at ISR_ADDRESS.
- WAIT_STATES, 1, cycles between request acceptance and ack. Range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  core request; held high with stable addr/we/wdata until ack
- we  in  1  1 = store, 0 = load/fetch
- addr  in  MEMORY_ADDRESS_BITS (16)  byte address
- wdata  in  MEMORY_DATA_BITS (8)  store data
- ack  out  1  one-cycle completion pulse
- err  out  1  valid only with ack; 1 = unmapped address (or protected write, see Optional Feature)
- rdata  out  MEMORY_DATA_BITS (8)  load data, valid only with ack

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
- Reset values: ack=0, err=0, rdata=0x00, state=MR_IDLE, wait counter=0.
  - Array contents are not cleared by reset.
- FSM states and transitions:
  - MR_IDLE: if req=1, latch addr/we/wdata. Next state is MR_WAIT if WAIT_STATES>0, else MR_ACK. Counter loads WAIT_STATES-1.
  - MR_WAIT: counter decrements each cycle. At counter=0 go to MR_ACK.
  - MR_ACK: ack=1 for exactly this cycle. Next state is MR_IDLE.
- Latency: request sampled at edge T gives ack high in cycle T+1+WAIT_STATES.
- Throughput: one request per WAIT_STATES+2 cycles.
- Handshake:
  - Changes to addr/we/wdata after acceptance are ignored; the latched values are used.
  - The core must drop req on the edge ending the ack cycle unless it wants another access.
  - req still high in MR_IDLE is a new request (back-to-back allowed).
  - req dropping before ack does not cancel the access.
- Address decode (on the latched address):
  - low hit if addr < DEPTH;
  - ISR hit if ISR_ADDRESS ≤ addr < ISR_ADDRESS+ISR_DEPTH;
  - otherwise unmapped.
  - ISR window index = addr - ISR_ADDRESS (ISR_DEPTH-bit truncation).
- Reads: rdata is driven with the array byte in the MR_ACK cycle.
  - Unmapped: rdata=0x00, err=1.
- Writes: the array is updated on the edge ending the MR_ACK cycle.
  - Mapped: rdata=0x00.
  - Unmapped: write dropped, err=1.
- ack=0 outside MR_ACK. err and rdata are 0 outside MR_ACK.
- Reset asserted mid-operation (MR_WAIT or MR_ACK):
  - FSM returns to MR_IDLE; no ack is produced.
  - A pending write is discarded, even if reset coincides with the MR_ACK cycle.
- req during reset is ignored.

Optional Feature:
- Macro: MEM_RESPONDER_ISR_PROTECT_EN.
- Defined: stores that hit the ISR window are dropped and acked with err=1. ISR reads are unaffected.
- Undefined: the ISR window is writable like the low window.

Decomposition:
- Add to constants_pkg:
  - typedef enum bit [1:0] {MR_IDLE, MR_WAIT, MR_ACK} MemRespState;
  - parameter int MEM_WAIT_BITS = 4;
  - parameter int ISR_WINDOW_BYTES = 256.
- Bus widths come from MEMORY_ADDRESS_BITS, MEMORY_DATA_BITS and ISR_ADDRESS.
- One sub-module: sp_byte_ram (single-port, parameterised depth, synchronous write, combinational read), instantiated twice (low and ISR windows).

Test Plan:
- Reset then WAIT_STATES=1: store addr=0x0010 wdata=0xA5, then load 0x0010.
  - Required: each ack arrives 2 cycles after acceptance with err=0.
  - Required: load returns rdata=0xA5.
- Store 0xff00←0x3C, then load 0xff00 and load 0xffff (never written).
  - Required: 0xff00 returns 0x3C, err=0.
  - Required: 0xffff returns the stored/initial value, err=0.
  - Required with MEM_RESPONDER_ISR_PROTECT_EN: the store acks with err=1 and the following load does not return 0x3C.
- Load addr=0x0400 (DEPTH=1024) and store 0x8000←0x11.
  - Required: both ack with err=1.
  - Required: load rdata=0x00; no array change (re-reading 0x0000..0x03FF matches previous contents).
- WAIT_STATES=0: hold req high for three back-to-back loads at 0x0001, 0x0002, 0x0003.
  - Required: ack every 2nd cycle, three acks total, rdata matches preloaded bytes.
- Store 0x0020←0x77, then assert reset for 1 cycle during MR_WAIT.
  - Required: no ack; FSM back in MR_IDLE.
  - Required: subsequent load 0x0020 returns the old value, not 0x77.
- Change addr from 0x0005 to 0x0006 one cycle after acceptance with WAIT_STATES=3.
  - Required: ack at T+4 and data from 0x0005.
